frame_buffer_ctrl: RTL

Frame-buffer responder and arbiter sitting between the sprite/draw engines, the display scan-out and a single-port synchronous frame RAM. It accepts pixel writes over the write_en / frame_addr / frame_data / frame_write_valid handshake used by the draw engines. It serves display pixel reads and performs a hardware full-frame clear. It owns the only RAM port, issuing at most one RAM operation per cycle.

---
 rtl/frame_buffer_ctrl_if.sv | 55 +++++
 rtl/frame_buffer_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/frame_buffer_ctrl_if.sv
// Frame-buffer bus bundle: draw writes, display reads,
// clear control and the single RAM port.
interface frame_buffer_ctrl_if;
  logic        write_en;
  logic [16:0] frame_addr;
  logic [23:0] frame_data;
  logic        frame_write_valid;
  logic        disp_req;
  logic [16:0] disp_addr;
  logic [23:0] disp_data;
  logic        disp_valid;
  logic        clear_start;
  logic [23:0] clear_color;
  logic        clear_done;
  logic [16:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        mem_we;
  logic [23:0] mem_rdata;

  modport slave (
    input  write_en,
    input  frame_addr,
    input  frame_data,
    input  disp_req,
    input  disp_addr,
    input  clear_start,
    input  clear_color,
    input  mem_rdata,
    output frame_write_valid,
    output disp_data,
    output disp_valid,
    output clear_done,
    output mem_addr,
    output mem_wdata,
    output mem_we
  );

  modport master (
    output write_en,
    output frame_addr,
    output frame_data,
    output disp_req,
    output disp_addr,
    output clear_start,
    output clear_color,
    output mem_rdata,
    input  frame_write_valid,
    input  disp_data,
    input  disp_valid,
    input  clear_done,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we
  );
endinterface

// File: rtl/frame_buffer_ctrl.sv
// Frame RAM arbiter: display reads beat the clear
// engine, which beats draw writes; one RAM op per cycle.
module frame_buffer_ctrl #(
  parameter int unsigned FRAME_PIXELS = 76800
) (
  input logic               clk,
  input logic               rst_n,
  frame_buffer_ctrl_if.slave fb
);

  localparam logic [16:0] LIMIT = 17'(FRAME_PIXELS);
  localparam logic [16:0] LAST  = 17'(FRAME_PIXELS - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  state_e      state_q, state_d;
  logic [16:0] ptr_q, ptr_d;
  logic [23:0] color_q, color_d;
  logic [2:0]  pipe_q, pipe_d;
  logic [23:0] rdata_q, rdata_d;
  logic        fwv_q, fwv_d;
  logic        done_q, done_d;
  logic [16:0] addr_q, addr_d;
  logic [23:0] wdata_q, wdata_d;
  logic        we_q, we_d;

  logic        clr_go;
  logic        g_disp, g_clr, g_wr;
  logic [16:0] clr_addr;
  logic [23:0] clr_color;

  // A clear_start in IDLE issues address 0 in the same cycle.
  assign clr_go    = (state_q == CLEAR) || fb.clear_start;
  assign clr_addr  = (state_q == CLEAR) ? ptr_q : '0;
  assign clr_color = (state_q == CLEAR) ? color_q
                                        : fb.clear_color;

  assign g_disp = fb.disp_req;
  assign g_clr  = !fb.disp_req && clr_go;
  assign g_wr   = !fb.disp_req && !clr_go
               && fb.write_en && !fwv_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    color_d = color_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    fwv_d   = 1'b0;
    done_d  = 1'b0;
    pipe_d  = {pipe_q[1:0], fb.disp_req};
    rdata_d = pipe_q[1] ? fb.mem_rdata : rdata_q;

    if (state_q == IDLE && fb.clear_start) begin
      state_d = CLEAR;
      color_d = fb.clear_color;
      ptr_d   = '0;
    end

    unique case (1'b1)
      g_disp: begin
        addr_d = fb.disp_addr;
      end
      g_clr: begin
        addr_d  = clr_addr;
        wdata_d = clr_color;
        we_d    = 1'b1;
        ptr_d   = clr_addr + 17'd1;
        if (clr_addr == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
          done_d  = 1'b1;
        end
      end
      g_wr: begin
        addr_d  = fb.frame_addr;
        wdata_d = fb.frame_data;
        we_d    = fb.frame_addr < LIMIT;
        fwv_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      color_q <= '0;
      pipe_q  <= '0;
      rdata_q <= '0;
      fwv_q   <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      color_q <= color_d;
      pipe_q  <= pipe_d;
      rdata_q <= rdata_d;
      fwv_q   <= fwv_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign fb.frame_write_valid = fwv_q;
  assign fb.disp_valid        = pipe_q[2];
  assign fb.disp_data         = rdata_q;
  assign fb.clear_done        = done_q;
  assign fb.mem_addr          = addr_q;
  assign fb.mem_wdata         = wdata_q;
  assign fb.mem_we            = we_q;

endmodule
